// File: rtl/sccb_pkg.sv
// sccb_pkg: state encoding and constants for the SCCB register target.
// Read path in sccb_target is built only with SCCB_TARGET_RD_EN defined.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_AH,
    ST_AH_ACK,
    ST_AL,
    ST_AL_ACK,
    ST_WDATA,
    ST_WD_ACK,
    ST_RDATA,
    ST_RD_MACK,
    ST_IGNORE
  } sccb_st_e;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h3c;
  localparam int         SYNC_DEPTH     = 2;

  function automatic logic is_ack_st(input sccb_st_e s);
    return (s == ST_DEV_ACK) || (s == ST_AH_ACK) ||
           (s == ST_AL_ACK)  || (s == ST_WD_ACK);
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: SCL/SDA synchronizer plus edge, START and STOP detect.
// Events are registered; they trail the pin change by three clocks.
module sccb_line_sync
  import sccb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic scl_lvl,
  output logic sda_lvl
);

  logic [SYNC_DEPTH:0] r_scl;
  logic [SYNC_DEPTH:0] r_sda;
  logic [SYNC_DEPTH:0] r_arm;
  logic r_rise, r_fall, r_start, r_stop;
  logic w_scl_c, w_scl_p, w_sda_c, w_sda_p, w_arm;

  assign w_scl_c = r_scl[SYNC_DEPTH-1];
  assign w_scl_p = r_scl[SYNC_DEPTH];
  assign w_sda_c = r_sda[SYNC_DEPTH-1];
  assign w_sda_p = r_sda[SYNC_DEPTH];
  // no events until the pipeline holds real pin samples after reset
  assign w_arm   = r_arm[SYNC_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl   <= '1;
      r_sda   <= '1;
      r_arm   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_scl   <= {r_scl[SYNC_DEPTH-1:0], scl_i};
      r_sda   <= {r_sda[SYNC_DEPTH-1:0], sda_i};
      r_arm   <= {r_arm[SYNC_DEPTH-1:0], 1'b1};
      r_rise  <= w_arm & w_scl_c & ~w_scl_p;
      r_fall  <= w_arm & ~w_scl_c & w_scl_p;
      r_start <= w_arm & w_scl_c & w_scl_p & w_sda_p & ~w_sda_c;
      r_stop  <= w_arm & w_scl_c & w_scl_p & ~w_sda_p & w_sda_c;
    end
  end

  assign scl_rise  = r_rise;
  assign scl_fall  = r_fall;
  assign start_det = r_start;
  assign stop_det  = r_stop;
  assign scl_lvl   = r_scl[SYNC_DEPTH];
  assign sda_lvl   = r_sda[SYNC_DEPTH];

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C device end presenting register accesses as strobes.
// Define SCCB_TARGET_RD_EN to build the read path (RDATA/RD_MACK, reg_rd).
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter logic       BIT_CTRL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic [15:0] wr_cnt
);

  sccb_st_e    r_st, w_nxt;
  logic        w_rise, w_fall, w_start, w_stop, w_sda, w_unused_scl;
  logic [7:0]  r_sh, r_wdata;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr, r_wcnt;
  logic        r_wr, r_rw;
  logic        w_full, w_dev_ok, w_cnt_st, w_oe, w_busy;
  logic [7:0]  w_tx;
  logic        w_mack;

  sccb_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (w_rise),
    .scl_fall  (w_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .scl_lvl   (w_unused_scl),
    .sda_lvl   (w_sda)
  );

  assign w_full   = (r_cnt == 4'd8);
  assign w_cnt_st = (r_st == ST_DEV) || (r_st == ST_AH) ||
                    (r_st == ST_AL) || (r_st == ST_WDATA) ||
                    (r_st == ST_RDATA);

`ifdef SCCB_TARGET_RD_EN
  assign w_dev_ok = (r_sh[7:1] == SLAVE_ADDR);
`else
  assign w_dev_ok = (r_sh == {SLAVE_ADDR, 1'b0});
`endif

  always_ff @(posedge clk) begin
    if (rst) r_st <= ST_IDLE;
    else     r_st <= w_nxt;
  end

  // bytes and ACK slots advance on SCL fall, so SDA moves only while SCL is low
  always_comb begin
    w_nxt = r_st;
    if (w_stop) begin
      w_nxt = ST_IDLE;
    end else if (w_start) begin
      w_nxt = ST_DEV;
    end else if (w_fall) begin
      unique case (r_st)
        ST_DEV:     if (w_full) w_nxt = w_dev_ok ? ST_DEV_ACK : ST_IGNORE;
        ST_DEV_ACK: w_nxt = r_rw ? ST_RDATA : (BIT_CTRL ? ST_AH : ST_AL);
        ST_AH:      if (w_full) w_nxt = ST_AH_ACK;
        ST_AH_ACK:  w_nxt = ST_AL;
        ST_AL:      if (w_full) w_nxt = ST_AL_ACK;
        ST_AL_ACK:  w_nxt = ST_WDATA;
        ST_WDATA:   if (w_full) w_nxt = ST_WD_ACK;
        ST_WD_ACK:  w_nxt = ST_WDATA;
        ST_RDATA:   if (w_full) w_nxt = ST_RD_MACK;
        ST_RD_MACK: w_nxt = w_mack ? ST_IGNORE : ST_RDATA;
        default:    w_nxt = r_st;
      endcase
    end
  end

  always_comb begin
    w_oe   = 1'b0;
    w_busy = (r_st != ST_IDLE);
    if (is_ack_st(r_st))      w_oe = 1'b1;
    else if (r_st == ST_RDATA) w_oe = ~w_tx[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh    <= 8'h00;
      r_cnt   <= 4'd0;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
      r_wr    <= 1'b0;
      r_wcnt  <= 16'h0000;
      r_rw    <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      if (w_start || w_stop) begin
        r_cnt <= 4'd0;
      end else if (w_rise && w_cnt_st && !w_full) begin
        r_sh  <= {r_sh[6:0], w_sda};
        r_cnt <= r_cnt + 4'd1;
        if (r_st == ST_WDATA && r_cnt == 4'd7) begin
          r_wdata <= {r_sh[6:0], w_sda};
          r_wr    <= 1'b1;
          if (r_wcnt != 16'hffff) r_wcnt <= r_wcnt + 16'd1;
        end
      end else if (w_fall) begin
        if (w_full) r_cnt <= 4'd0;
        unique case (r_st)
          ST_DEV: if (w_full) r_rw <= r_sh[0];
          ST_AH:  if (w_full) r_addr[15:8] <= r_sh;
          ST_AL: begin
            if (w_full) begin
              r_addr[7:0] <= r_sh;
              if (!BIT_CTRL) r_addr[15:8] <= 8'h00;
            end
          end
          ST_WD_ACK:  r_addr <= r_addr + 16'd1;
          ST_RD_MACK: if (!w_mack) r_addr <= r_addr + 16'd1;
          default: ;
        endcase
      end
    end
  end

`ifdef SCCB_TARGET_RD_EN
  logic       r_rd, r_ld, r_mack;
  logic [7:0] r_tx;

  // bank data lands two clocks after the strobe; SDA stays released until then
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd   <= 1'b0;
      r_ld   <= 1'b0;
      r_mack <= 1'b1;
      r_tx   <= 8'hff;
    end else begin
      r_rd <= 1'b0;
      r_ld <= r_rd;
      if (w_start || w_stop) begin
        r_ld <= 1'b0;
        r_tx <= 8'hff;
      end else if (w_fall && w_nxt == ST_RDATA && r_st != ST_RDATA) begin
        r_rd <= 1'b1;
        r_tx <= 8'hff;
      end else if (w_fall && r_st == ST_RDATA) begin
        r_tx <= {r_tx[6:0], 1'b1};
      end else if (r_ld) begin
        r_tx <= reg_rdata;
      end
      if (w_rise && r_st == ST_RD_MACK) r_mack <= w_sda;
    end
  end

  assign w_tx   = r_tx;
  assign w_mack = r_mack;
  assign reg_rd = r_rd;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^reg_rdata;
  assign w_tx   = 8'hff;
  assign w_mack = 1'b1;
  assign reg_rd = 1'b0;
`endif

  assign sda_oe    = w_oe;
  assign busy      = w_busy;
  assign reg_wr    = r_wr;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign wr_cnt    = r_wcnt;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed SCCB master driving sccb_target over an open-drain bus.
// Read scenario follows SCCB_TARGET_RD_EN the same way the design does.
module tb_sccb_target;
  import sccb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, reg_wr, reg_rd, busy;
  logic [15:0] reg_addr, wr_cnt;
  logic [7:0]  reg_wdata, reg_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int q = 10;
  int oe_cnt = 0;
  int rd_cnt = 0;
  int hi_chg = 0;
  logic oe_d = 1'b0;
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [7:0]  tx_q[$];

  always #10 clk = ~clk;

  assign sda_bus   = sda_m & ~sda_oe;
  assign reg_rdata = (reg_addr == 16'h300A) ? 8'h56 :
                     (reg_addr == 16'h300B) ? 8'h40 : 8'hEE;

  sccb_target dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .wr_cnt    (wr_cnt)
  );

  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      wa_q.push_back(reg_addr);
      wd_q.push_back(reg_wdata);
    end
    if (reg_rd === 1'b1) rd_cnt++;
    if (sda_oe === 1'b1) oe_cnt++;
    if (scl_m && (sda_oe !== oe_d)) hi_chg++;
    oe_d = sda_oe;
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    wa_q.delete();
    wd_q.delete();
    oe_cnt = 0;
    rd_cnt = 0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wq(q);
    scl_m = 1'b1; wq(q);
    sda_m = 1'b0; wq(q);
    scl_m = 1'b0; wq(q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq(q);
    scl_m = 1'b1; wq(q);
    sda_m = 1'b1; wq(2 * q);
  endtask

  task automatic put_bit(input logic b, output logic s);
    sda_m = b;    wq(q);
    scl_m = 1'b1; wq(q);
    s = sda_bus;  wq(q);
    scl_m = 1'b0; wq(q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) put_bit(b[i], s);
    put_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, s);
      b[i] = s;
    end
    put_bit(mack, s);
  endtask

  task automatic send_bytes(output int acks);
    logic a;
    acks = 0;
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], a);
      if (a === 1'b0) acks++;
    end
  endtask

  task automatic send_all(output int acks);
    bus_start();
    send_bytes(acks);
    bus_stop();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wq(4);
    n_cmp++;
    if ({sda_oe, reg_wr, reg_rd, busy} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 0000", {sda_oe, reg_wr, reg_rd, busy});
    end
    n_cmp++;
    if (reg_addr !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_addr: got %h want 0000", reg_addr);
    end
    n_cmp++;
    if ({reg_wdata, wr_cnt} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 000000", {reg_wdata, wr_cnt});
    end
    rst = 1'b0;
    wq(5);
  endtask

  task automatic test_single_write();
    int acks;
    clr();
    q = 50;
    tx_q = '{8'h78, 8'h30, 8'h08, 8'h82};
    bus_start();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_busy: got %b want 1", busy);
    end
    send_bytes(acks);
    bus_stop();
    q = 10;
    n_cmp++;
    if (acks !== 4) begin
      n_bad++;
      $display("FAIL single_acks: got %0d want 4", acks);
    end
    n_cmp++;
    if (wa_q.size() !== 1) begin
      n_bad++;
      $display("FAIL single_nwr: got %0d want 1", wa_q.size());
    end
    if (wa_q.size() >= 1) begin
      n_cmp++;
      if ({wa_q[0], wd_q[0]} !== 24'h300882) begin
        n_bad++;
        $display("FAIL single_strobe: got %h want 300882", {wa_q[0], wd_q[0]});
      end
    end
    n_cmp++;
    if ({busy, wr_cnt} !== {1'b0, 16'd1}) begin
      n_bad++;
      $display("FAIL single_end: got %b/%0d want 0/1", busy, wr_cnt);
    end
  endtask

  task automatic test_burst();
    int acks;
    clr();
    tx_q = '{8'h78, 8'h43, 8'h00, 8'h61, 8'h62, 8'h63};
    send_all(acks);
    n_cmp++;
    if ({acks, wa_q.size()} !== {32'd6, 32'd3}) begin
      n_bad++;
      $display("FAIL burst_cnt: got %0d acks %0d wr want 6/3", acks, wa_q.size());
    end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      n_cmp++;
      if ({wa_q[i], wd_q[i]} !== {16'h4300 + 16'(i), 8'h61 + 8'(i)}) begin
        n_bad++;
        $display("FAIL burst_%0d: got %h/%h want %h/%h", i, wa_q[i], wd_q[i],
                 16'h4300 + 16'(i), 8'h61 + 8'(i));
      end
    end
    n_cmp++;
    if (wr_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL burst_wrcnt: got %0d want 4", wr_cnt);
    end
  endtask

  task automatic test_bad_addr();
    int acks;
    clr();
    tx_q = '{8'h7a, 8'h30, 8'h00, 8'h55};
    send_all(acks);
    n_cmp++;
    if ({acks, oe_cnt, wa_q.size()} !== 96'h0) begin
      n_bad++;
      $display("FAIL bad_addr: got acks %0d oe %0d wr %0d want 0/0/0",
               acks, oe_cnt, wa_q.size());
    end
    clr();
    tx_q = '{8'h78, 8'h12, 8'h34, 8'h5a};
    send_all(acks);
    n_cmp++;
    if ({acks, wa_q.size()} !== {32'd4, 32'd1}) begin
      n_bad++;
      $display("FAIL bad_next_cnt: got %0d/%0d want 4/1", acks, wa_q.size());
    end
    if (wa_q.size() >= 1) begin
      n_cmp++;
      if ({wa_q[0], wd_q[0]} !== 24'h12345a) begin
        n_bad++;
        $display("FAIL bad_next: got %h want 12345a", {wa_q[0], wd_q[0]});
      end
    end
  endtask

  task automatic test_read();
    int acks;
    logic a;
    logic [7:0] b1, b2;
    clr();
`ifdef SCCB_TARGET_RD_EN
    tx_q = '{8'h78, 8'h30, 8'h0A};
    send_all(acks);
    bus_start();
    send_byte(8'h79, a);
    recv_byte(1'b0, b1);
    recv_byte(1'b1, b2);
    bus_stop();
    n_cmp++;
    if ({acks, 31'd0, a} !== {32'd3, 32'd0}) begin
      n_bad++;
      $display("FAIL read_acks: got %0d/%b want 3/0", acks, a);
    end
    n_cmp++;
    if ({b1, b2} !== 16'h5640) begin
      n_bad++;
      $display("FAIL read_data: got %h want 5640", {b1, b2});
    end
    n_cmp++;
    if ({rd_cnt, reg_addr} !== {32'd2, 16'h300B}) begin
      n_bad++;
      $display("FAIL read_strobes: got %0d @%h want 2 @300b", rd_cnt, reg_addr);
    end
`else
    acks = 0;
    bus_start();
    send_byte(8'h79, a);
    recv_byte(1'b1, b1);
    bus_stop();
    n_cmp++;
    if (a !== 1'b1) begin
      n_bad++;
      $display("FAIL read_nack: got ack %b want 1", a);
    end
    n_cmp++;
    if ({rd_cnt, oe_cnt} !== {acks, 32'd0}) begin
      n_bad++;
      $display("FAIL read_quiet: got rd %0d oe %0d want 0/0", rd_cnt, oe_cnt);
    end
`endif
  endtask

  task automatic test_abort();
    int acks;
    logic s;
    clr();
    tx_q = '{8'h78, 8'h11, 8'h22};
    bus_start();
    send_bytes(acks);
    for (int i = 0; i < 4; i++) put_bit(i[0], s);
    bus_stop();
    n_cmp++;
    if ({wa_q.size(), 31'd0, sda_oe, reg_addr} !== {64'd0, 16'h1122}) begin
      n_bad++;
      $display("FAIL abort_stop: got wr %0d oe %b addr %h want 0/0/1122",
               wa_q.size(), sda_oe, reg_addr);
    end
    clr();
    tx_q = '{8'h78, 8'h55};
    bus_start();
    send_bytes(acks);
    for (int i = 0; i < 3; i++) put_bit(1'b1, s);
    tx_q = '{8'h78, 8'h20, 8'h00, 8'h99};
    bus_start();
    send_bytes(acks);
    bus_stop();
    n_cmp++;
    if ({acks, wa_q.size()} !== {32'd4, 32'd1}) begin
      n_bad++;
      $display("FAIL abort_rstart_cnt: got %0d/%0d want 4/1", acks, wa_q.size());
    end
    if (wa_q.size() >= 1) begin
      n_cmp++;
      if ({wa_q[0], wd_q[0]} !== 24'h200099) begin
        n_bad++;
        $display("FAIL abort_rstart: got %h want 200099", {wa_q[0], wd_q[0]});
      end
    end
    n_cmp++;
    if (wr_cnt !== 16'd6) begin
      n_bad++;
      $display("FAIL abort_wrcnt: got %0d want 6", wr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    logic s;
    clr();
    tx_q = '{8'h78, 8'h30};
    bus_start();
    send_bytes(acks);
    for (int i = 0; i < 8; i++) put_bit(1'b0, s);
    n_cmp++;
    if (sda_oe !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_ack: got oe %b want 1", sda_oe);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (sda_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_release: got oe %b want 0", sda_oe);
    end
    wq(2);
    rst = 1'b0;
    clr();
    put_bit(1'b1, s);
    send_byte(8'h77, s);
    bus_stop();
    n_cmp++;
    if ({wa_q.size(), oe_cnt, wr_cnt} !== {64'd0, 16'd0}) begin
      n_bad++;
      $display("FAIL rstmid_quiet: got wr %0d oe %0d cnt %0d want 0/0/0",
               wa_q.size(), oe_cnt, wr_cnt);
    end
    clr();
    tx_q = '{8'h78, 8'h00, 8'h50, 8'h11};
    send_all(acks);
    n_cmp++;
    if ({acks, wa_q.size(), wr_cnt} !== {32'd4, 32'd1, 16'd1}) begin
      n_bad++;
      $display("FAIL rstmid_next_cnt: got %0d/%0d/%0d want 4/1/1",
               acks, wa_q.size(), wr_cnt);
    end
    if (wa_q.size() >= 1) begin
      n_cmp++;
      if ({wa_q[0], wd_q[0]} !== 24'h005011) begin
        n_bad++;
        $display("FAIL rstmid_next: got %h want 005011", {wa_q[0], wd_q[0]});
      end
    end
  endtask

  task automatic test_wrap();
    int acks;
    clr();
    tx_q = '{8'h78, 8'hff, 8'hff, 8'ha1, 8'ha2};
    send_all(acks);
    n_cmp++;
    if (wa_q.size() !== 2) begin
      n_bad++;
      $display("FAIL wrap_nwr: got %0d want 2", wa_q.size());
    end
    if (wa_q.size() >= 2) begin
      n_cmp++;
      if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== 48'hffffa1_0000a2) begin
        n_bad++;
        $display("FAIL wrap_strobes: got %h/%h %h/%h want ffff/a1 0000/a2",
                 wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
    end
    n_cmp++;
    if (wr_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL wrap_wrcnt: got %0d want 3", wr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_bad_addr();
    test_read();
    test_abort();
    test_reset_mid();
    test_wrap();
    n_cmp++;
    if (hi_chg !== 0) begin
      n_bad++;
      $display("FAIL sda_while_scl_high: got %0d changes want 0", hi_chg);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
